// File: rtl/mcmem_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package : mcmem_pkg -- shared constants for the wait-state memory responder
// Rev     : 1.0
//------------------------------------------------------------------------------
package mcmem_pkg;

    localparam int CNT_W      = 4;
    localparam int DEFAULT_AW = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcmem_ws_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Interface : mcmem_ws_if -- CPU <-> memory request/ready bus
// Rev       : 1.0
//------------------------------------------------------------------------------
interface mcmem_ws_if;

    logic        req;
    logic [31:0] adr;
    logic [31:0] tom;
    logic        wmem;
    logic [31:0] fromm;
    logic        ready;
    logic        err;

    modport master (
        output req, adr, tom, wmem,
        input  fromm, ready, err
    );

    modport slave (
        input  req, adr, tom, wmem,
        output fromm, ready, err
    );

endinterface
`default_nettype wire

// File: rtl/mc_ram_array.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : mc_ram_array -- 2**AW x 32 word array, sync write / async read
// Rev    : 1.0
//------------------------------------------------------------------------------
module mc_ram_array
    import mcmem_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_addr,
    input  wire logic [31:0]   i_wdata,
    output logic      [31:0]   o_rdata
);

    // Contents survive reset on purpose; the array has no reset port.
    logic [31:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/mcmem_ws.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : mcmem_ws -- wait-state memory responder, LAT wait cycles per access
// Rev    : 1.0
//------------------------------------------------------------------------------
module mcmem_ws
    import mcmem_pkg::*;
#(
    parameter int AW  = DEFAULT_AW,
    parameter int LAT = 2
) (
    input  wire logic  clock,
    input  wire logic  resetn,
    mcmem_ws_if.slave  bus
);

    generate
        if (LAT < 0 || LAT > (2**CNT_W) - 1) begin : g_lat_check
            $error("mcmem_ws: LAT out of range 0..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_LAT = CNT_W'(LAT);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [AW+1:0]    r_adr;
    logic [31:0]      r_tom;
    logic             r_wmem;
    logic [31:0]      r_fromm;
    logic             r_ready;
    logic             r_err;

    logic             w_accept;
    logic             w_direct;
    logic             w_last;
    logic             w_enter_resp;
    logic [AW+1:0]    w_adr;
    logic [31:0]      w_tom;
    logic             w_wmem;
    logic             w_aligned;
    logic             w_we;
    logic [31:0]      w_rdata;
    logic [31:0]      w_resp_data;
    logic             w_unused_adr;

    assign w_accept     = bus.req && (r_state == ST_IDLE || r_state == ST_RESP);
    assign w_direct     = w_accept && (c_LAT == '0);
    assign w_last       = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1));
    assign w_enter_resp = w_direct || w_last;

    // With zero latency the access happens on the accepting edge, before the latches load.
    assign w_adr  = w_direct ? bus.adr[AW+1:0] : r_adr;
    assign w_tom  = w_direct ? bus.tom         : r_tom;
    assign w_wmem = w_direct ? bus.wmem        : r_wmem;

    assign w_aligned = is_aligned(w_adr[1:0]);
    // resetn gate: a zero-latency request seen while reset is held must not write.
    assign w_we      = resetn && w_enter_resp && w_aligned && w_wmem;

    assign w_resp_data  = !w_aligned ? 32'd0 : (w_wmem ? w_tom : w_rdata);
    assign w_unused_adr = ^bus.adr[31:AW+2];

    mc_ram_array #(
        .AW (AW)
    ) u_ram (
        .clk     (clock),
        .i_we    (w_we),
        .i_addr  (w_adr[AW+1:2]),
        .i_wdata (w_tom),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_adr   <= '0;
            r_tom   <= '0;
            r_wmem  <= 1'b0;
            r_fromm <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= w_enter_resp;
            r_err   <= w_enter_resp && !w_aligned;
            if (w_enter_resp) begin
                r_fromm <= w_resp_data;
            end

            if (w_accept) begin
                r_adr   <= bus.adr[AW+1:0];
                r_tom   <= bus.tom;
                r_wmem  <= bus.wmem;
                r_cnt   <= c_LAT;
                r_state <= (c_LAT == '0) ? ST_RESP : ST_WAIT;
            end else begin
                case (r_state)
                    ST_WAIT: begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= ST_RESP;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.fromm = r_fromm;
    assign bus.ready = r_ready;
    assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mcmem_ws.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_mcmem_ws -- bench for mcmem_ws at LAT = 0, 2 and 3
// Rev    : 1.0
//------------------------------------------------------------------------------
module tb_mcmem_ws;

    localparam int AW = 6;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mcmem_ws_if bus0 ();
    mcmem_ws_if bus1 ();
    mcmem_ws_if bus2 ();

    logic        req_d  [3];
    logic [31:0] adr_d  [3];
    logic [31:0] tom_d  [3];
    logic        wmem_d [3];
    logic        rdy    [3];
    logic        er     [3];
    logic [31:0] dat    [3];

    assign bus0.req = req_d[0];  assign bus0.adr = adr_d[0];
    assign bus0.tom = tom_d[0];  assign bus0.wmem = wmem_d[0];
    assign bus1.req = req_d[1];  assign bus1.adr = adr_d[1];
    assign bus1.tom = tom_d[1];  assign bus1.wmem = wmem_d[1];
    assign bus2.req = req_d[2];  assign bus2.adr = adr_d[2];
    assign bus2.tom = tom_d[2];  assign bus2.wmem = wmem_d[2];
    assign rdy[0] = bus0.ready;  assign er[0] = bus0.err;  assign dat[0] = bus0.fromm;
    assign rdy[1] = bus1.ready;  assign er[1] = bus1.err;  assign dat[1] = bus1.fromm;
    assign rdy[2] = bus2.ready;  assign er[2] = bus2.err;  assign dat[2] = bus2.fromm;

    mcmem_ws #(.AW(AW), .LAT(0)) u_lat0 (.clock(clk), .resetn(resetn), .bus(bus0));
    mcmem_ws #(.AW(AW), .LAT(2)) u_lat2 (.clock(clk), .resetn(resetn), .bus(bus1));
    mcmem_ws #(.AW(AW), .LAT(3)) u_lat3 (.clock(clk), .resetn(resetn), .bus(bus2));

    int          lat_of [3] = '{0, 2, 3};
    logic [31:0] mem_m  [3][2**AW];
    int          tests_run    = 0;
    int          tests_failed = 0;

    // Reference: one access at transaction level, updating the model array.
    task automatic model(input int i, input logic [31:0] a, input logic [31:0] d, input logic w,
                         output logic [31:0] exp_d, output logic exp_e);
        if (a[1:0] != 2'b00) begin
            exp_d = 32'd0;
            exp_e = 1'b1;
        end else if (w) begin
            mem_m[i][a[AW+1:2]] = d;
            exp_d = d;
            exp_e = 1'b0;
        end else begin
            exp_d = mem_m[i][a[AW+1:2]];
            exp_e = 1'b0;
        end
    endtask

    // Issue one request (called at a falling edge); latency counts edges after the accepting one.
    task automatic xact(input int i, input logic [31:0] a, input logic [31:0] d, input logic w,
                        output int latency, output logic [31:0] data, output logic e,
                        output logic rdy_after);
        req_d[i] = 1'b1; adr_d[i] = a; tom_d[i] = d; wmem_d[i] = w;
        @(posedge clk);
        @(negedge clk);
        req_d[i] = 1'b0;
        latency = -1; data = '0; e = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (rdy[i]) begin
                latency = n; data = dat[i]; e = er[i];
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        rdy_after = rdy[i];
    endtask

    task automatic test_reset_state;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({rdy[i], er[i], dat[i]} !== 34'd0) begin
                tests_failed++;
                $display("FAIL reset_state[%0d]: ready=%b err=%b fromm=%h, expected 0 0 0",
                         i, rdy[i], er[i], dat[i]);
            end
        end
    endtask

    task automatic test_preload;
        int lat; logic [31:0] d, ed; logic e, ee, ra;
        for (int i = 0; i < 3; i++) begin
            for (int wd = 0; wd < 2**AW; wd++) begin
                logic [31:0] v;
                v = $urandom;
                xact(i, 32'(wd * 4), v, 1'b1, lat, d, e, ra);
                model(i, 32'(wd * 4), v, 1'b1, ed, ee);
                tests_run++;
                if (lat !== lat_of[i] || d !== ed || e !== ee || ra !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL preload[%0d] w%0d: lat=%0d d=%h err=%b rdy_after=%b, expected lat=%0d d=%h err=%b rdy_after=0",
                             i, wd, lat, d, e, ra, lat_of[i], ed, ee);
                end
            end
        end
    endtask

    task automatic test_write_read;
        int lat; logic [31:0] d; logic e, ra;
        xact(1, 32'h0000_0008, 32'h1234_5678, 1'b1, lat, d, e, ra);
        mem_m[1][2] = 32'h1234_5678;
        tests_run++;
        if (lat !== 2 || d !== 32'h1234_5678 || e !== 1'b0 || ra !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_lat2: lat=%0d d=%h err=%b rdy_after=%b, expected lat=2 d=12345678 err=0 rdy_after=0",
                     lat, d, e, ra);
        end
        xact(1, 32'h0000_0008, 32'h0, 1'b0, lat, d, e, ra);
        tests_run++;
        if (lat !== 2 || d !== 32'h1234_5678 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_lat2: lat=%0d d=%h err=%b, expected lat=2 d=12345678 err=0", lat, d, e);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] d; logic e, ra;
        for (int k = 0; k < 4; k++) begin
            xact(0, 32'(k * 4), 32'(k + 1), 1'b1, lat, d, e, ra);
            mem_m[0][k] = 32'(k + 1);
        end
        req_d[0] = 1'b1; wmem_d[0] = 1'b0; adr_d[0] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (rdy[0] !== 1'b1 || er[0] !== 1'b0 || dat[0] !== 32'(k + 1)) begin
                tests_failed++;
                $display("FAIL b2b_lat0[%0d]: ready=%b err=%b fromm=%h, expected 1 0 %h",
                         k, rdy[0], er[0], dat[0], 32'(k + 1));
            end
            if (k < 3) adr_d[0] = 32'((k + 1) * 4);
            else       req_d[0] = 1'b0;
        end
        @(negedge clk);
        tests_run++;
        if (rdy[0] !== 1'b0 || dat[0] !== 32'd4) begin
            tests_failed++;
            $display("FAIL b2b_end: ready=%b fromm=%h, expected ready=0 fromm=00000004", rdy[0], dat[0]);
        end
    endtask

    task automatic test_misaligned;
        int lat; logic [31:0] d, ed; logic e, ee, ra;
        logic [31:0] adrs [3] = '{32'h0000_0006, 32'h0000_0005, 32'h0000_0004};
        logic        wrs  [3] = '{1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            logic [31:0] v;
            v = $urandom;
            xact(1, adrs[t], v, wrs[t], lat, d, e, ra);
            model(1, adrs[t], v, wrs[t], ed, ee);
            tests_run++;
            if (lat !== 2 || d !== ed || e !== ee || ra !== 1'b0) begin
                tests_failed++;
                $display("FAIL misaligned[%0d] adr=%h: lat=%0d d=%h err=%b, expected lat=2 d=%h err=%b",
                         t, adrs[t], lat, d, e, ed, ee);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int pulses = 0;
        int first  = -1;
        logic [31:0] fd = '0;
        req_d[2] = 1'b1; adr_d[2] = 32'h0000_0010; wmem_d[2] = 1'b0; tom_d[2] = 32'h0;
        @(posedge clk);
        @(negedge clk);
        adr_d[2] = 32'h0000_0020;
        @(posedge clk);
        @(negedge clk);
        req_d[2] = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (rdy[2]) begin
                pulses++;
                if (first < 0) begin first = n; fd = dat[2]; end
            end
            @(negedge clk);
        end
        tests_run++;
        if (pulses !== 1 || first !== 3 || fd !== mem_m[2][4]) begin
            tests_failed++;
            $display("FAIL busy_ignore: pulses=%0d at=%0d d=%h, expected pulses=1 at=3 d=%h",
                     pulses, first, fd, mem_m[2][4]);
        end
        tests_run++;
        if (dat[2] !== mem_m[2][4]) begin
            tests_failed++;
            $display("FAIL fromm_hold: fromm=%h, expected %h", dat[2], mem_m[2][4]);
        end
    endtask

    task automatic test_wrap;
        int lat; logic [31:0] d; logic e, ra;
        xact(1, 32'h0000_0104, 32'hA5A5_A5A5, 1'b1, lat, d, e, ra);
        mem_m[1][1] = 32'hA5A5_A5A5;
        xact(1, 32'h0000_0004, 32'h0, 1'b0, lat, d, e, ra);
        tests_run++;
        if (lat !== 2 || d !== 32'hA5A5_A5A5 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap: lat=%0d d=%h err=%b, expected lat=2 d=a5a5a5a5 err=0", lat, d, e);
        end
    endtask

    task automatic test_random;
        int lat; logic [31:0] d, ed; logic e, ee, ra;
        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < 30; t++) begin
                logic [31:0] a, v, hi;
                logic [1:0]  lo;
                logic        w;
                hi = $urandom;
                lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                a  = {hi[31:AW+2], 6'($urandom_range(0, 63)), lo};
                v  = $urandom;
                w  = 1'($urandom_range(0, 1));
                xact(i, a, v, w, lat, d, e, ra);
                model(i, a, v, w, ed, ee);
                tests_run++;
                if (lat !== lat_of[i] || d !== ed || e !== ee || ra !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL random[%0d.%0d] adr=%h w=%b: lat=%0d d=%h err=%b rdy_after=%b, expected lat=%0d d=%h err=%b",
                             i, t, a, w, lat, d, e, ra, lat_of[i], ed, ee);
                end
            end
        end
    endtask

    task automatic test_reset_midwait;
        int lat; logic [31:0] d, ed; logic e, ee, ra;
        xact(2, 32'h0000_0010, 32'h0, 1'b1, lat, d, e, ra);
        mem_m[2][4] = 32'h0;
        mem_m[2][5] = 32'hCAFE_F00D;
        xact(2, 32'h0000_0014, 32'hCAFE_F00D, 1'b1, lat, d, e, ra);
        req_d[2] = 1'b1; adr_d[2] = 32'h0000_0010; tom_d[2] = 32'hDEAD_BEEF; wmem_d[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_d[2] = 1'b0;
        #2 resetn = 1'b0;
        #1;
        tests_run++;
        if (rdy[2] !== 1'b0 || dat[2] !== 32'd0 || er[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: ready=%b err=%b fromm=%h, expected 0 0 00000000", rdy[2], er[2], dat[2]);
        end
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        xact(2, 32'h0000_0010, 32'h0, 1'b0, lat, d, e, ra);
        model(2, 32'h0000_0010, 32'h0, 1'b0, ed, ee);
        tests_run++;
        if (lat !== 3 || d !== ed || e !== ee) begin
            tests_failed++;
            $display("FAIL reset_no_write: lat=%0d d=%h err=%b, expected lat=3 d=%h err=%b", lat, d, e, ed, ee);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_d[i] = 1'b0; adr_d[i] = '0; tom_d[i] = '0; wmem_d[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        test_reset_state;
        test_preload;
        test_write_read;
        test_back_to_back;
        test_misaligned;
        test_busy_ignore;
        test_wrap;
        test_random;
        test_reset_midwait;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
